// File: rtl/alu_control_seq.sv
// ALU control sequencer: decodes Op/funct3/funct7 into an ALU operation code and
// paces multiply/divide-class results through a latency counter before handshaking them out.
module alu_control_seq #(
    parameter int OPW      = 5,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 8,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           valid_in,
    output logic           ready_in,
    input  logic [1:0]     Op,
    input  logic [2:0]     funct3,
    input  logic [6:0]     funct7,
    output logic           valid_out,
    input  logic           ready_out,
    output logic [OPW-1:0] ALUOp,
    output logic           illegal,
    output logic           busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
    typedef enum logic [1:0] {C_SINGLE, C_MUL, C_DIV} cls_e;

    typedef struct packed {
        logic [4:0] code;
        logic       ill;
        cls_e       cls;
    } dec_t;

    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [OPW-1:0]   aluop_q, aluop_d;
    logic             illegal_q, illegal_d;
    dec_t             dec;
    logic             accept;

    // Base integer ops shared by R-type (funct7=0) and I-type.
    function automatic logic [4:0] base_code(input logic [2:0] f3);
        logic [4:0] c;
        case (f3)
            3'b000:  c = 5'd0;
            3'b001:  c = 5'd7;
            3'b010:  c = 5'd11;
            3'b011:  c = 5'd10;
            3'b100:  c = 5'd6;
            3'b101:  c = 5'd8;
            3'b110:  c = 5'd5;
            default: c = 5'd4;
        endcase
        return c;
    endfunction

    function automatic logic [4:0] m_code(input logic [2:0] f3);
        logic [4:0] c;
        case (f3)
            3'b000:  c = 5'd12;
            3'b001:  c = 5'd13;
            3'b010:  c = 5'd20;
            3'b011:  c = 5'd17;
            3'b100:  c = 5'd18;
            3'b101:  c = 5'd14;
            3'b110:  c = 5'd19;
            default: c = 5'd15;
        endcase
        return c;
    endfunction

    always_comb begin
        dec = '{code: 5'd0, ill: 1'b0, cls: C_SINGLE};
        case (Op)
            2'b00: dec.code = 5'd0;
            2'b01: dec.code = 5'd1;
            2'b10: begin
                case (funct7)
                    7'b0000000: dec.code = base_code(funct3);
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec.code = 5'd1;
                        else if (funct3 == 3'b101) dec.code = 5'd9;
                        else                       dec.ill  = 1'b1;
                    end
                    7'b0000001: begin
                        if (ENABLE_M) dec.code = m_code(funct3);
                        else          dec.ill  = 1'b1;
                    end
                    default: dec.ill = 1'b1;
                endcase
            end
            default: dec.code = base_code(funct3);
        endcase
        if (!dec.ill) begin
            case (dec.code)
                5'd12, 5'd13, 5'd17, 5'd20: dec.cls = C_MUL;
                5'd14, 5'd15, 5'd18, 5'd19: dec.cls = C_DIV;
                default:                    dec.cls = C_SINGLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            aluop_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            aluop_q   <= aluop_d;
            illegal_q <= illegal_d;
        end
    end

    assign accept = valid_in & ready_in & ~flush;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        aluop_d   = aluop_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
        end else if (accept) begin
            aluop_d   = dec.ill ? '1 : OPW'(dec.code);
            illegal_d = dec.ill;
            case (dec.cls)
                C_MUL:   begin state_d = S_EXEC; cnt_d = MUL_CNT; end
                C_DIV:   begin state_d = S_EXEC; cnt_d = DIV_CNT; end
                default: begin state_d = S_DONE; cnt_d = 8'd0;    end
            endcase
        end else begin
            case (state_q)
                S_EXEC: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = S_DONE;
                end
                S_DONE: if (ready_out) state_d = S_IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        ready_in  = (state_q == S_IDLE) | ((state_q == S_DONE) & ready_out);
        valid_out = (state_q == S_DONE);
        busy      = (state_q == S_EXEC);
    end

    assign ALUOp   = aluop_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: directed scenarios plus random traffic against a
// transaction-level model (pending result + remaining-latency count).
module tb_alu_control_seq;
    localparam int OPW = 5, MUL_LAT = 3, DIV_LAT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, valid_in, ready_in, valid_out, ready_out, illegal, busy;
    logic [1:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [OPW-1:0] ALUOp;

    logic b_rst, b_flush, b_valid_in, b_ready_in, b_valid_out, b_ready_out, b_illegal, b_busy;
    logic [1:0] b_Op;
    logic [2:0] b_funct3;
    logic [6:0] b_funct7;
    logic [7:0] b_ALUOp;

    alu_control_seq #(.OPW(OPW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_in(ready_in),
        .Op(Op), .funct3(funct3), .funct7(funct7), .valid_out(valid_out),
        .ready_out(ready_out), .ALUOp(ALUOp), .illegal(illegal), .busy(busy));

    alu_control_seq #(.OPW(8), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ENABLE_M(1'b0)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush), .valid_in(b_valid_in), .ready_in(b_ready_in),
        .Op(b_Op), .funct3(b_funct3), .funct7(b_funct7), .valid_out(b_valid_out),
        .ready_out(b_ready_out), .ALUOp(b_ALUOp), .illegal(b_illegal), .busy(b_busy));

    int n_chk = 0, n_fail = 0;

    int alu_tab[8] = '{0, 7, 11, 10, 6, 8, 5, 4};
    int m_tab[8]   = '{12, 13, 20, 17, 18, 14, 19, 15};

    // model: pending result, cycles still to wait, expected code/illegal
    bit m_have = 0;
    int m_rem  = 0;
    int m_code = 0;
    bit m_ill  = 0;

    function automatic int ref_code(input logic [1:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, input bit enm);
        if (op == 2'd0) return 0;
        if (op == 2'd1) return 1;
        if (op == 2'd3) return alu_tab[f3];
        if (f7 == 7'h00) return alu_tab[f3];
        if (f7 == 7'h20) begin
            if (f3 == 3'd0) return 1;
            if (f3 == 3'd5) return 9;
            return -1;
        end
        if (f7 == 7'h01 && enm) return m_tab[f3];
        return -1;
    endfunction

    function automatic int ref_lat(input int c);
        if (c inside {12, 13, 17, 20}) return MUL_LAT;
        if (c inside {14, 15, 18, 19}) return DIV_LAT;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic ro, input logic fl, input logic rs);
        bit ve, rdy;
        int c;
        @(negedge clk);
        valid_in = v; Op = op; funct3 = f3; funct7 = f7;
        ready_out = ro; flush = fl; rst = rs;
        #1;
        ve  = m_have && (m_rem == 0);
        rdy = !m_have || (ve && ro);
        chk("valid_out", 32'(valid_out), 32'(ve));
        chk("busy",      32'(busy),      32'(m_have && m_rem > 0));
        chk("ready_in",  32'(ready_in),  32'(rdy));
        chk("ALUOp",     32'(ALUOp),     32'(m_code));
        chk("illegal",   32'(illegal),   32'(m_ill));
        @(posedge clk);
        if (rs) begin
            m_have = 0; m_rem = 0; m_code = 0; m_ill = 0;
        end else if (fl) begin
            m_have = 0; m_rem = 0;
        end else if (v && rdy) begin
            c = ref_code(op, f3, f7, 1'b1);
            m_have = 1;
            if (c < 0) begin
                m_code = (1 << OPW) - 1; m_ill = 1; m_rem = 0;
            end else begin
                m_code = c; m_ill = 0; m_rem = ref_lat(c) - 1;
            end
        end else if (m_have && m_rem > 0) begin
            m_rem--;
        end else if (ve && ro) begin
            m_have = 0;
        end
    endtask

    task automatic bstep(input logic v, input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
        @(negedge clk);
        b_valid_in = v; b_Op = op; b_funct3 = f3; b_funct7 = f7;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1; flush = 0; valid_in = 0; Op = 0; funct3 = 0; funct7 = 0; ready_out = 1;
        b_rst = 1; b_flush = 0; b_valid_in = 0; b_Op = 0; b_funct3 = 0; b_funct7 = 0; b_ready_out = 1;

        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 1);
        b_rst = 0;
        #2;
        chk("rst_ALUOp", 32'(ALUOp), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_ready", 32'(ready_in), 1);

        // sub then back-to-back I-type AND
        step(1, 2, 3'b000, 7'h20, 1, 0, 0);
        #2 chk("sub_code", 32'(ALUOp), 1);
        step(1, 3, 3'b111, 7'h00, 1, 0, 0);
        #2 chk("b2b_and", 32'(ALUOp), 4);
        step(0, 0, 0, 0, 1, 0, 0);

        // divide: seven busy cycles then result
        step(1, 2, 3'b100, 7'h01, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 1, 0, 0);
        #2 chk("div_valid", 32'(valid_out), 1);
        chk("div_code", 32'(ALUOp), 18);
        step(0, 0, 0, 0, 1, 0, 0);

        // I-type ignores funct7; unknown funct7 is illegal
        step(1, 3, 3'b101, 7'h20, 1, 0, 0);
        #2 chk("srli_f7", 32'(ALUOp), 8);
        step(1, 2, 3'b000, 7'h02, 1, 0, 0);
        #2 chk("ill_code", 32'(ALUOp), 31);
        chk("ill_flag", 32'(illegal), 1);
        step(0, 0, 0, 0, 1, 0, 0);

        // multiply held under back-pressure
        step(1, 2, 3'b000, 7'h01, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 3, 3'b110, 0, 0, 0, 0);
            #2 chk("mul_hold", 32'(ALUOp), 12);
        end
        step(1, 3, 3'b100, 0, 1, 0, 0);
        #2 chk("resume", 32'(ALUOp), 6);
        step(0, 0, 0, 0, 1, 0, 0);

        // flush mid-divide, then reset mid-divide
        step(1, 2, 3'b101, 7'h01, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        #2 chk("flush_busy", 32'(busy), 0);
        chk("flush_valid", 32'(valid_out), 0);
        chk("flush_keep", 32'(ALUOp), 14);
        step(1, 2, 3'b110, 7'h01, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        #2 chk("rst_busy", 32'(busy), 0);
        chk("rst_code", 32'(ALUOp), 0);

        for (int i = 0; i < 600; i++) begin
            logic [6:0] f7;
            case ($urandom_range(3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            step(1'($urandom_range(3) != 0), 2'($urandom), 3'($urandom), f7,
                 1'($urandom_range(3) != 0), 1'($urandom_range(40) == 0),
                 1'($urandom_range(60) == 0));
        end

        // M extension disabled, 8-bit ALUOp
        bstep(1, 2, 3'b000, 7'h01);
        chk("nom_ill", 32'(b_illegal), 1);
        chk("nom_code", 32'(b_ALUOp), 255);
        chk("nom_valid", 32'(b_valid_out), 1);
        bstep(1, 2, 3'b101, 7'h20);
        chk("nom_sra", 32'(b_ALUOp), 9);
        chk("nom_sra_ill", 32'(b_illegal), 0);
        bstep(1, 2, 3'b100, 7'h01);
        chk("nom_div_busy", 32'(b_busy), 0);
        chk("nom_div_code", 32'(b_ALUOp), 255);
        bstep(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_control_seq.md
ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 Parameter OPW, default 5: ALUOp output width; legal range 5..8.
REQ-002 Parameter MUL_LAT, default 3: cycles from accept to valid_out for multiply-class ops; legal range 2..255.
REQ-003 Parameter DIV_LAT, default 8: cycles from accept to valid_out for divide/remainder-class ops; legal range 2..255.
REQ-004 Parameter ENABLE_M, default 1: 0 makes every funct7=0000001 code illegal.
REQ-005 clk  input  1  sole clock; every register updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous abort of any in-flight op.
REQ-008 valid_in  input  1  request present.
REQ-009 ready_in  output  1  block can accept this cycle.
REQ-010 Op  input  2  major class: 00 address-add, 01 compare-sub, 10 R-type, 11 I-type.
REQ-011 funct3  input  3  minor opcode.
REQ-012 funct7  input  7  R-type qualifier.
REQ-013 valid_out  output  1  ALUOp/illegal valid.
REQ-014 ready_out  input  1  consumer accepts the result.
REQ-015 ALUOp  output  OPW  registered ALU operation code, zero-extended from 5 bits.
REQ-016 illegal  output  1  captured request had no legal mapping.
REQ-017 busy  output  1  multi-cycle op in progress.

Function
REQ-018 Decode: Op 00->0; Op 01->1.
REQ-019 Decode Op 10, {funct7,funct3}:
- 0000000_000->0, 0100000_000->1, 0000000_111->4, 0000000_110->5, 0000000_100->6, 0000000_001->7, 0000000_101->8, 0100000_101->9, 0000000_011->10, 0000000_010->11.
- 0000001_000->12, 001->13, 010->20, 011->17, 100->18, 101->14, 110->19, 111->15.
REQ-020 Decode Op 11, funct3 only: 000->0, 111->4, 110->5, 100->6, 001->7, 101->8, 011->10, 010->11; funct7 ignored.
REQ-021 Any other combination (incl. Op 11 funct3 ≠ the eight listed, and M codes when ENABLE_M=0) is illegal: ALUOp = all-ones over OPW bits, illegal = 1, treated as single-cycle.
REQ-022 Class: codes 12,13,17,20 = MUL (MUL_LAT); 14,15,18,19 = DIV (DIV_LAT); all others, including illegal, single-cycle.
REQ-023 FSM states: IDLE, EXEC, DONE; 8-bit down-counter cnt.
REQ-024 Accept occurs when valid_in & ready_in; ready_in = (state==IDLE) | (state==DONE & ready_out).
REQ-025 On accept, decode result and illegal are registered; single-cycle -> DONE; MUL/DIV -> EXEC with cnt = LAT-1.
REQ-026 EXEC: cnt==1 -> DONE, else cnt decrements; busy = 1 exactly in EXEC.
REQ-027 Latency: accept at edge T gives valid_out high from T+1 (single-cycle) or T+LAT (MUL/DIV).
REQ-028 DONE: valid_out=1; ALUOp/illegal held stable until ready_out; ready_out without new accept -> IDLE; ready_out with accept -> back-to-back capture, zero bubble.
REQ-029 ALUOp and illegal change only on accept; inputs outside accept cycles are ignored.
REQ-030 flush (rst low): next state IDLE, valid_out=0, busy=0, cnt=0, no accept that cycle; ALUOp retains last value.
REQ-031 Priority: rst > flush > accept/advance.

Reset
REQ-032 rst high at an edge: state IDLE, cnt 0, ALUOp 0, illegal 0, valid_out 0, busy 0, ready_in 1 the following cycle; applies mid-EXEC or mid-DONE identically.

Verification
REQ-033 Op=10,{0100000,000}, ready_out=1: valid_out at T+1, ALUOp=1, illegal=0, ready_in stays 1; back-to-back Op=11,funct3=111 gives ALUOp=4 at T+2.
REQ-034 Op=10,{0000001,100}, DIV_LAT=8: busy T+1..T+7, valid_out at T+8, ALUOp=18, ready_in=0 during EXEC.
REQ-035 Op=11,funct3=000... funct3=101 with funct7=0100000: ALUOp=8 (funct7 ignored); Op=10,{0000010,000}: ALUOp=all-ones (31 at OPW=5, 255 at OPW=8), illegal=1.
REQ-036 MUL op with ready_out=0 for 5 cycles after valid_out: valid_out, ALUOp=12 held; valid_in ignored; accept resumes on ready_out=1.
REQ-037 flush at T+2 of a DIV op, then rst asserted during a later EXEC: both return IDLE next cycle with valid_out=0, busy=0; ENABLE_M=0 run: {0000001,000} -> illegal=1 at T+1.
